// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline: control-bundle layout,
// register-destination encodings and the NOP bundle.
package cpu_pkg;

    localparam int CTRL_W = 14;

    // Control bundle field positions, MSB first.
    localparam int CTRL_BRANCH      = 13;
    localparam int CTRL_REGWRITE    = 12;
    localparam int CTRL_REGDST_HI   = 11;
    localparam int CTRL_REGDST_LO   = 10;
    localparam int CTRL_MEMREAD     = 9;
    localparam int CTRL_MEMWRITE    = 8;
    localparam int CTRL_MEMTOREG_HI = 7;
    localparam int CTRL_MEMTOREG_LO = 6;
    localparam int CTRL_ALUSRC1     = 5;
    localparam int CTRL_ALUSRC2     = 4;
    localparam int CTRL_ALUOP_HI    = 3;
    localparam int CTRL_ALUOP_LO    = 0;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;
    localparam logic [1:0] REGDST_ZERO = 2'b11;

    localparam int LINK_REG = 31;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    function automatic logic [1:0] ctrl_regdst(input logic [CTRL_W-1:0] c);
        return c[CTRL_REGDST_HI:CTRL_REGDST_LO];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector: compares the ID instruction's
// source registers against a load currently sitting in EX.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic              i_ex_valid,
    input  logic [CTRL_W-1:0] i_ex_ctrl,
    input  logic [RAW-1:0]    i_ex_rt,
    input  logic              i_id_valid,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic [RAW-1:0]    i_id_rs,
    input  logic [RAW-1:0]    i_id_rt,
    input  logic              i_ex_flush,
    output logic              o_load_use_stall
);

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_ex_is_load;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_uses_rs = ~i_id_ctrl[CTRL_ALUSRC1];
    // Stores read rt as the data to write even when the ALU takes the immediate.
    assign w_uses_rt = ~i_id_ctrl[CTRL_ALUSRC2] | i_id_ctrl[CTRL_MEMWRITE];

    assign w_ex_is_load = i_ex_valid & i_ex_ctrl[CTRL_MEMREAD] & (i_ex_rt != '0);
    assign w_rs_hit     = w_uses_rs & (i_id_rs == i_ex_rt);
    assign w_rt_hit     = w_uses_rt & (i_id_rt == i_ex_rt);

    assign o_load_use_stall = w_ex_is_load & i_id_valid & (w_rs_hit | w_rt_hit) & ~i_ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core with load-use bubble
// insertion, flush handling and a saturating stall-event counter.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RAW   = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DW-1:0]     id_pc_plus4,
    input  logic [DW-1:0]     id_rs_data,
    input  logic [DW-1:0]     id_rt_data,
    input  logic [DW-1:0]     id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [RAW-1:0]    id_rs,
    input  logic [RAW-1:0]    id_rt,
    input  logic [RAW-1:0]    id_rd,
    input  logic [5:0]        id_funct,
    input  logic              ex_flush,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DW-1:0]     ex_pc_plus4,
    output logic [DW-1:0]     ex_rs_data,
    output logic [DW-1:0]     ex_rt_data,
    output logic [DW-1:0]     ex_imm,
    output logic [4:0]        ex_shamt,
    output logic [RAW-1:0]    ex_rs,
    output logic [RAW-1:0]    ex_rt,
    output logic [RAW-1:0]    ex_dst,
    output logic [5:0]        ex_funct,
    output logic [CNT_W-1:0]  stall_count
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DW-1:0]     r_pc_plus4;
    logic [DW-1:0]     r_rs_data;
    logic [DW-1:0]     r_rt_data;
    logic [DW-1:0]     r_imm;
    logic [4:0]        r_shamt;
    logic [RAW-1:0]    r_rs;
    logic [RAW-1:0]    r_rt;
    logic [RAW-1:0]    r_dst;
    logic [5:0]        r_funct;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_stall;
    logic              w_kill;
    logic [RAW-1:0]    w_dst;

    hazard_detect #(
        .RAW (RAW)
    ) u_hazard_detect (
        .i_ex_valid       (r_valid),
        .i_ex_ctrl        (r_ctrl),
        .i_ex_rt          (r_rt),
        .i_id_valid       (id_valid),
        .i_id_ctrl        (id_ctrl),
        .i_id_rs          (id_rs),
        .i_id_rt          (id_rt),
        .i_ex_flush       (ex_flush),
        .o_load_use_stall (w_stall)
    );

    // Flush and load-use bubble both turn the next EX slot into a NOP.
    assign w_kill = ex_flush | w_stall;

    always_comb begin
        w_dst = '0;
        case (ctrl_regdst(id_ctrl))
            REGDST_RT:   w_dst = id_rt;
            REGDST_RD:   w_dst = id_rd;
            REGDST_LINK: w_dst = RAW'(LINK_REG);
            default:     w_dst = '0;
        endcase
        if (!id_ctrl[CTRL_REGWRITE]) begin
            w_dst = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_pc_plus4 <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_dst      <= '0;
            r_funct    <= '0;
        end else if (w_kill) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_pc_plus4 <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_dst      <= '0;
            r_funct    <= '0;
        end else begin
            r_valid    <= id_valid;
            r_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
            r_pc_plus4 <= id_pc_plus4;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= id_imm;
            r_shamt    <= id_shamt;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_dst      <= id_valid ? w_dst : '0;
            r_funct    <= id_funct;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign load_use_stall = w_stall;
    assign ex_valid       = r_valid;
    assign ex_ctrl        = r_ctrl;
    assign ex_pc_plus4    = r_pc_plus4;
    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm         = r_imm;
    assign ex_shamt       = r_shamt;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_dst         = r_dst;
    assign ex_funct       = r_funct;
    assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: capture, dst resolution, load-use
// bubbles, flush priority, async reset and counter saturation.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [13:0] id_ctrl;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic        ex_flush;

    logic        load_use_stall, ex_valid;
    logic [13:0] ex_ctrl;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_dst;
    logic [5:0]  ex_funct;
    logic [15:0] stall_count;

    // Narrow-counter instance, sharing inputs, used to reach saturation quickly.
    logic        s_stall, s_valid;
    logic [13:0] s_ctrl;
    logic [31:0] s_pc, s_rsd, s_rtd, s_imm;
    logic [4:0]  s_shamt, s_rs, s_rt, s_dst;
    logic [5:0]  s_funct;
    logic [3:0]  s_count;

    int n_vec = 0;
    int n_bad = 0;

    // Control bundles: Branch,RegWrite,RegDst[2],MemRead,MemWrite,MemtoReg[2],ALUSrc1,ALUSrc2,ALUOp[4]
    localparam logic [13:0] C_ADD  = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0010};
    localparam logic [13:0] C_JAL  = {1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 4'b0000};
    localparam logic [13:0] C_LW   = {1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 4'b0000};
    localparam logic [13:0] C_SW   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'b0000};
    localparam logic [13:0] C_SLL  = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0100};
    localparam logic [13:0] C_LUI  = {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0111};
    localparam logic [13:0] C_BEQ  = {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0001};
    localparam logic [13:0] C_R11  = {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0010};
    localparam logic [13:0] C_NWR  = {1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0010};

    id_ex_stage #(.DW(32), .RAW(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct), .ex_flush(ex_flush),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .ex_funct(ex_funct), .stall_count(stall_count)
    );

    id_ex_stage #(.DW(32), .RAW(5), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct), .ex_flush(ex_flush),
        .load_use_stall(s_stall), .ex_valid(s_valid), .ex_ctrl(s_ctrl),
        .ex_pc_plus4(s_pc), .ex_rs_data(s_rsd), .ex_rt_data(s_rtd),
        .ex_imm(s_imm), .ex_shamt(s_shamt), .ex_rs(s_rs), .ex_rt(s_rt),
        .ex_dst(s_dst), .ex_funct(s_funct), .stall_count(s_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [13:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic f);
        id_valid    = v;
        id_ctrl     = c;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        ex_flush    = f;
        id_pc_plus4 = 32'h0040_0000;
        id_rs_data  = 32'h0;
        id_rt_data  = 32'h0;
        id_imm      = 32'h0;
        id_shamt    = 5'd0;
        id_funct    = 6'h20;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 14'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        #1;
        check_val("rst_valid", {31'b0, ex_valid}, 32'h0);
        check_val("rst_ctrl", {18'b0, ex_ctrl}, 32'h0);
        check_val("rst_dst", {27'b0, ex_dst}, 32'h0);
        check_val("rst_pc", ex_pc_plus4, 32'h0);
        check_val("rst_count", {16'b0, stall_count}, 32'h0);
        check_val("rst_stall", {31'b0, load_use_stall}, 32'h0);

        // add $3,$1,$2 with distinct payload
        drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        id_pc_plus4 = 32'h0040_0104;
        id_rs_data  = 32'hAAAA_0001;
        id_rt_data  = 32'h5555_0002;
        id_imm      = 32'h0000_FFFC;
        id_shamt    = 5'd7;
        step();
        check_val("add_valid", {31'b0, ex_valid}, 32'h1);
        check_val("add_ctrl", {18'b0, ex_ctrl}, {18'b0, C_ADD});
        check_val("add_dst", {27'b0, ex_dst}, 32'd3);
        check_val("add_pc", ex_pc_plus4, 32'h0040_0104);
        check_val("add_rsd", ex_rs_data, 32'hAAAA_0001);
        check_val("add_rtd", ex_rt_data, 32'h5555_0002);
        check_val("add_imm", ex_imm, 32'h0000_FFFC);
        check_val("add_shamt", {27'b0, ex_shamt}, 32'd7);
        check_val("add_rs", {27'b0, ex_rs}, 32'd1);
        check_val("add_rt", {27'b0, ex_rt}, 32'd2);
        check_val("add_funct", {26'b0, ex_funct}, 32'h20);

        drive(1'b1, C_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        check_val("jal_dst", {27'b0, ex_dst}, 32'd31);
        check_val("jal_valid", {31'b0, ex_valid}, 32'h1);

        drive(1'b1, C_R11, 5'd1, 5'd2, 5'd9, 1'b0);
        step();
        check_val("regdst11_dst", {27'b0, ex_dst}, 32'd0);
        drive(1'b1, C_NWR, 5'd1, 5'd2, 5'd9, 1'b0);
        step();
        check_val("nowrite_dst", {27'b0, ex_dst}, 32'd0);
        drive(1'b0, C_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        check_val("idinv_valid", {31'b0, ex_valid}, 32'h0);
        check_val("idinv_ctrl", {18'b0, ex_ctrl}, 32'h0);

        // Asynchronous reset in the middle of a held add
        drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        check_val("pre_arst_valid", {31'b0, ex_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check_val("arst_valid", {31'b0, ex_valid}, 32'h0);
        check_val("arst_ctrl", {18'b0, ex_ctrl}, 32'h0);
        #1 reset = 1'b0;

        // lw $5 then add $6,$5,$1: one bubble, then add captured
        drive(1'b1, C_LW, 5'd2, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
        #1;
        check_val("lu_add_stall", {31'b0, load_use_stall}, 32'h1);
        step();
        check_val("bub_valid", {31'b0, ex_valid}, 32'h0);
        check_val("bub_ctrl", {18'b0, ex_ctrl}, 32'h0);
        check_val("bub_dst", {27'b0, ex_dst}, 32'h0);
        check_val("bub_count", {16'b0, stall_count}, 32'd1);
        check_val("bub_nostall", {31'b0, load_use_stall}, 32'h0);
        step();
        check_val("after_bub_ctrl", {18'b0, ex_ctrl}, {18'b0, C_ADD});
        check_val("after_bub_dst", {27'b0, ex_dst}, 32'd6);
        check_val("after_bub_count", {16'b0, stall_count}, 32'd1);

        // sll uses rt only; lui uses neither; sw uses rt through MemWrite
        drive(1'b1, C_LW, 5'd2, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, C_SLL, 5'd0, 5'd5, 5'd6, 1'b0);
        #1;
        check_val("sll_stall", {31'b0, load_use_stall}, 32'h1);
        step();
        drive(1'b1, C_LW, 5'd2, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, C_LUI, 5'd5, 5'd7, 5'd0, 1'b0);
        #1;
        check_val("lui_nostall", {31'b0, load_use_stall}, 32'h0);
        step();
        drive(1'b1, C_LW, 5'd2, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, C_SW, 5'd2, 5'd5, 5'd0, 1'b0);
        #1;
        check_val("sw_stall", {31'b0, load_use_stall}, 32'h1);
        step();
        check_val("sw_count", {16'b0, stall_count}, 32'd3);

        // Load into $0 never creates a hazard
        drive(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, C_ADD, 5'd0, 5'd1, 5'd6, 1'b0);
        #1;
        check_val("zero_nostall", {31'b0, load_use_stall}, 32'h0);
        step();

        // Flush with a valid beq, then flush over a stall condition
        drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
        step();
        check_val("flush_valid", {31'b0, ex_valid}, 32'h0);
        check_val("flush_ctrl", {18'b0, ex_ctrl}, 32'h0);
        drive(1'b1, C_LW, 5'd2, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b1);
        #1;
        check_val("flush_over_stall", {31'b0, load_use_stall}, 32'h0);
        step();
        check_val("flush2_valid", {31'b0, ex_valid}, 32'h0);
        check_val("flush2_count", {16'b0, stall_count}, 32'd3);

        // 12 more stalls: wide counter 15, narrow counter exactly at its max
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, C_LW, 5'd5, 5'd5, 5'd0, 1'b0);
            step();
            drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
            step();
        end
        check_val("cnt15_wide", {16'b0, stall_count}, 32'd15);
        check_val("cnt15_narrow", {28'b0, s_count}, 32'd15);
        drive(1'b1, C_LW, 5'd5, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b0);
        #1;
        check_val("sat_stall", {31'b0, s_stall}, 32'h1);
        step();
        check_val("sat_wide", {16'b0, stall_count}, 32'd16);
        check_val("sat_narrow", {28'b0, s_count}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Sits directly downstream of the instruction decoder/control unit.
- Latches the decoded control bundle and ID operands into EX on every clk.
- Detects load-use hazards against the instruction it currently holds, raises a stall to PC/IF-ID, and injects a bubble.
- Honours a flush from EX branch/jump resolution.

Parameters:
- DW, 32, datapath width (pc, register data, immediate).
- RAW, 5, register-address width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  14  control bundle from decoder; field order in package
- id_pc_plus4  in  DW  PC+4 of ID instruction
- id_rs_data  in  DW  register-file read port 1
- id_rt_data  in  DW  register-file read port 2
- id_imm  in  DW  extended/lui-shifted immediate
- id_shamt  in  5  shift amount
- id_rs  in  RAW  rs field
- id_rt  in  RAW  rt field
- id_rd  in  RAW  rd field
- id_funct  in  6  funct field
- ex_flush  in  1  branch/jump taken in EX; kill ID/EX contents
- load_use_stall  out  1  freeze PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  14  registered control bundle
- ex_pc_plus4  out  DW  registered PC+4
- ex_rs_data  out  DW  registered rs data
- ex_rt_data  out  DW  registered rt data
- ex_imm  out  DW  registered immediate
- ex_shamt  out  5  registered shift amount
- ex_rs  out  RAW  registered rs
- ex_rt  out  RAW  registered rt
- ex_dst  out  RAW  resolved write register
- ex_funct  out  6  registered funct
- stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, active-high): all outputs 0, ex_valid=0, ex_ctrl=0 (RegWrite=0, MemWrite=0, i.e. a NOP), stall_count=0. reset asserted mid-instruction discards it immediately, with no clk edge required.
- id_ctrl bit order (MSB..LSB): Branch, RegWrite, RegDst[1:0], MemRead, MemWrite, MemtoReg[1:0], ALUSrc1, ALUSrc2, ALUOp[3:0].
- ex_dst resolution at capture:
  - RegDst 00 -> id_rt
  - 01 -> id_rd
  - 10 -> 31
  - 11 -> 0
  - Forced to 0 when RegWrite=0.
- Operand use:
  - uses_rs = ~ALUSrc1.
  - uses_rt = ~ALUSrc2 | MemWrite.
- load_use_stall, combinational from registered state plus ID inputs: ex_valid & ex_ctrl.MemRead & ex_rt!=0 & id_valid & ((uses_rs & id_rs==ex_rt) | (uses_rt & id_rt==ex_rt)) & ~ex_flush.
- Per-edge priority: flush > load-use bubble > normal capture.
  - Flush: next ex_valid=0, ex_ctrl=0, ex_dst=0; data fields don't-care (hold 0).
  - Bubble: same as flush. The ID instruction is held upstream and re-presented next cycle.
  - Normal: capture all id_* fields; ex_valid <= id_valid. If id_valid=0, ex_ctrl is forced to 0.
- Latency: exactly 1 clk, ID to EX.
- A load followed by a dependent instruction costs exactly one bubble. The second cycle sees a bubble in EX, so no repeated stall.
- stall_count increments once per cycle with load_use_stall=1 and saturates at 2^CNT_W-1 (no wrap).
- There is no stall input from downstream. The pipeline never stalls below EX.

Decomposition:
- Package cpu_pkg holds:
  - The ctrl-bundle width constant (14).
  - Bit-index constants for each field.
  - RegDst encodings.
  - The link register constant (31).
  - The NOP bundle constant.
- One natural sub-module: hazard_detect, combinational, producing load_use_stall. The register bank stays in id_ex_stage.

Test Plan:
- Reset, then release: all outputs 0. Assert reset asynchronously mid-capture of an add -> ex_valid drops to 0 before the next clk.
- add $3,$1,$2 (RegDst=01, rd=3) with id_valid=1 -> next cycle ex_dst=3, ex_valid=1, ex_ctrl equal to the input. jal (RegDst=10) -> ex_dst=31.
- lw $5 in EX, then ID add $6,$5,$1 -> load_use_stall=1 for one cycle; next EX ctrl=0; following cycle add is captured; stall_count=1.
- lw $5 in EX, then ID sll $6,$5,2 (ALUSrc1=1, uses_rt) -> stall. ID lui $7 (uses neither rs/rt match) -> no stall. lw $0 in EX, then use of $0 -> no stall.
- ex_flush=1 concurrent with a valid ID beq -> next ex_valid=0, ex_ctrl=0; flush coincident with a stall condition -> load_use_stall=0.
- Force 65535 stall events -> stall_count=16'hFFFF; one more stall -> stays 16'hFFFF.
